// File: rtl/trap_vector_sequencer.sv
// LC-3 TRAP sequencer: latch vector, zero-extend, save return PC to link register, fetch routine address, load PC.
// Latency: done 4 cycles after start with zero-wait memory; each memory wait cycle adds 1. New start only accepted in IDLE.
module trap_vector_sequencer #(
    parameter logic [2:0] LINK_REG    = 3'd7,
    parameter int         MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  trapvect8,
    input  logic [15:0] pc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  zext_in,
    input  logic [15:0] zext_out,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        reg_we,
    output logic [2:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic        pc_ld,
    output logic [15:0] pc_next
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VEC   = 3'd1,
        SAVE  = 3'd2,
        FETCH = 3'd3,
        JUMP  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     vec_q;
    logic [15:0]    pc_q;
    logic [15:0]    addr_q;
    logic [15:0]    tgt_q;
    logic [CW-1:0]  cnt;
    logic           timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec_q  <= '0;
            pc_q   <= '0;
            addr_q <= '0;
            tgt_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    vec_q <= trapvect8;
                    pc_q  <= pc;
                end
                VEC:  addr_q <= zext_out;
                SAVE: cnt <= '0;
                FETCH: begin
                    if (mem_ack)
                        tgt_q <= mem_rdata;
                    else if (!timeout_hit)
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        zext_in   = vec_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        reg_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        pc_ld     = 1'b0;
        pc_next   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = VEC;
            end
            // Upper byte must be zero; anything else means the extender is broken.
            VEC: state_nxt = (zext_out[15:8] != 8'h00) ? ERR : SAVE;
            SAVE: begin
                reg_we    = 1'b1;
                reg_waddr = LINK_REG;
                reg_wdata = pc_q;
                state_nxt = FETCH;
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack)
                    state_nxt = JUMP;
                else if (timeout_hit)
                    state_nxt = ERR;
            end
            JUMP: begin
                done      = 1'b1;
                pc_ld     = 1'b1;
                pc_next   = tgt_q;
                state_nxt = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_vector_sequencer.sv
// Randomized scoreboard bench for trap_vector_sequencer with a reactive memory and zero-extender model.
module tb_trap_vector_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  trapvect8 = '0;
    logic [15:0] pc = '0;
    logic        busy, done, err;
    logic [7:0]  zext_in;
    logic [15:0] zext_out;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic        pc_ld;
    logic [15:0] pc_next;

    trap_vector_sequencer #(.LINK_REG(3'd7), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .trapvect8(trapvect8), .pc(pc),
        .busy(busy), .done(done), .err(err), .zext_in(zext_in), .zext_out(zext_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .pc_ld(pc_ld), .pc_next(pc_next)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected observable events of one TRAP, in the order they appear.
    typedef enum int { EV_REG, EV_FETCH, EV_DONE } ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] val;
        int          n;
        int          lat;
    } exp_t;
    exp_t q[$];

    int          t0 = 0;
    bit          fault = 1'b0;
    int          cur_d = 0;
    logic [15:0] cur_rdata = '0;

    assign zext_out = {fault ? 8'h01 : 8'h00, zext_in};

    // Memory: ack arrives on FETCH cycle cur_d+1; random ack noise outside FETCH.
    int fcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack   = (fcnt == cur_d);
            mem_rdata = mem_ack ? cur_rdata : 16'($urandom);
            fcnt++;
        end else begin
            fcnt      = 0;
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
        end
    end

    // Reference: outcome of a TRAP from its vector, PC, fault, and memory wait count.
    task automatic run_txn(input logic [7:0] v, input logic [15:0] p, input logic [15:0] r,
                           input int d, input bit f);
        int   last;
        exp_t e;
        start     = 1'b1;
        trapvect8 = v;
        pc        = p;
        fault     = f;
        cur_d     = d;
        cur_rdata = r;
        t0        = cyc;
        if (f) begin
            last = 2;
            e = '{EV_DONE, 16'h0, 1, last}; q.push_back(e);
        end else begin
            last = (d < TO) ? 4 + d : 3 + TO;
            e = '{EV_REG, p, 0, 2}; q.push_back(e);
            e = '{EV_FETCH, {8'h00, v}, (d < TO) ? d + 1 : TO, last}; q.push_back(e);
            e = '{EV_DONE, r, (d < TO) ? 0 : 1, last}; q.push_back(e);
        end
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            start     = 1'($urandom);
            trapvect8 = 8'($urandom);
            pc        = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor
    bit          in_fetch = 1'b0;
    logic [15:0] faddr = '0;
    int          fcyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_fetch = 1'b0;
            end else begin
                chk("busy", busy, (q.size() != 0));
                if (reg_we) begin
                    if (q.size() == 0 || q[0].kind != EV_REG) chk("reg_we_unexpected", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("reg_waddr", reg_waddr, 3'd7);
                        chk("reg_wdata", reg_wdata, e.val);
                        chk("reg_we_lat", cyc - t0, e.lat);
                    end
                end
                if (in_fetch && !mem_req) begin
                    in_fetch = 1'b0;
                    if (q.size() == 0 || q[0].kind != EV_FETCH) chk("fetch_unexpected", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("mem_addr", faddr, e.val);
                        chk("fetch_cycles", fcyc, e.n);
                        chk("fetch_end_lat", cyc - t0, e.lat);
                    end
                end
                if (mem_req) begin
                    if (!in_fetch) begin
                        in_fetch = 1'b1;
                        faddr    = mem_addr;
                        fcyc     = 0;
                    end else if (mem_addr !== faddr) begin
                        chk("mem_addr_stable", mem_addr, faddr);
                    end
                    fcyc++;
                end
                if (done) begin
                    if (q.size() == 0 || q[0].kind != EV_DONE) chk("done_unexpected", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("err", err, e.n);
                        chk("pc_ld", pc_ld, !e.n);
                        if (e.n == 0) chk("pc_next", pc_next, e.val);
                        chk("done_lat", cyc - t0, e.lat);
                    end
                end else if (err || pc_ld) begin
                    chk("err_pc_ld_without_done", 1, 0);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {busy, done, err, mem_req, reg_we, pc_ld}, 6'b0);
        chk({tag, "_data"}, {zext_in, mem_addr, reg_waddr, reg_wdata, pc_next}, 59'b0);
    endtask

    initial begin
        exp_t e;
        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); trapvect8 = 8'($urandom); pc = 16'($urandom);
            #1 chk_all_zero("in_reset");
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #2 chk_all_zero("first_idle");
        @(negedge clk);

        // Directed: nominal, max vector with ack on the timeout cycle, timeout, fault
        run_txn(8'h25, 16'h3005, 16'h0FD0, 0, 1'b0);
        run_txn(8'hFF, 16'h1234, 16'hABCD, 3, 1'b0);
        run_txn(8'h23, 16'h4000, 16'h0400, 9, 1'b0);
        run_txn(8'h21, 16'h5000, 16'h0500, 0, 1'b0);
        run_txn(8'h25, 16'h3005, 16'h0FD0, 0, 1'b1);

        // Reset during FETCH
        start = 1'b1; trapvect8 = 8'h30; pc = 16'h6000; fault = 1'b0;
        cur_d = 99; t0 = cyc;
        e = '{EV_REG, 16'h6000, 0, 2}; q.push_back(e);
        e = '{EV_FETCH, 16'h0030, TO, 3 + TO}; q.push_back(e);
        e = '{EV_DONE, 16'h0, 1, 3 + TO}; q.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("mem_req_before_reset", mem_req, 1'b1);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_txn(8'h31, 16'h7000, 16'h0700, 1, 1'b0);

        // Random
        for (int i = 0; i < 40; i++)
            run_txn(8'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0));

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
